// File: rtl/imem_load_controller_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_load_controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned NB_WIDTH_DEFAULT = 32;
  localparam int unsigned NB_BYTE_DEFAULT  = 8;
  localparam int unsigned BYTES_PER_WORD   = NB_WIDTH_DEFAULT / NB_BYTE_DEFAULT;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  function automatic int unsigned bytes_per_word(input int unsigned nb_width,
                                                 input int unsigned nb_byte);
    return nb_width / nb_byte;
  endfunction

  // Counter width that still works when only one value is needed.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_load_controller_word_assembler.sv
// Collects UART bytes big-endian into words and watches for a stalled partial word.
module imem_load_controller_word_assembler
  import imem_load_controller_pkg::*;
#(
  parameter int unsigned NB_WIDTH       = 32,
  parameter int unsigned NB_BYTE        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_WIDTH       = 17
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                accept_en_i,
  input  logic                collect_i,
  input  logic                rx_valid_i,
  input  logic [NB_BYTE-1:0]  rx_data_i,
  output logic                word_valid_o,
  output logic [NB_WIDTH-1:0] word_o,
  output logic                timeout_o
);

  localparam int unsigned Bpw  = bytes_per_word(NB_WIDTH, NB_BYTE);
  localparam int unsigned CntW = cnt_width(Bpw);
  localparam logic [CntW-1:0]     LastByte = CntW'(Bpw - 1);
  localparam logic [TO_WIDTH-1:0] ToLimit  = TO_WIDTH'(TIMEOUT_CYCLES);

  logic [NB_WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic                accept;
  logic                partial;

  assign accept  = accept_en_i & rx_valid_i;
  assign partial = (cnt_q != '0);
  // Earlier bytes move up, so the first byte of a word ends in the MSBs.
  assign shifted = (shift_q << NB_BYTE) | NB_WIDTH'(rx_data_i);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
      to_d    = '0;
    end else if (accept) begin
      shift_d = shifted;
      cnt_d   = (cnt_q == LastByte) ? '0 : cnt_q + 1'b1;
      to_d    = '0;
    end else if (collect_i && partial) begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign word_valid_o = accept && !clear_i && (cnt_q == LastByte);
  assign word_o       = shifted;
  assign timeout_o    = collect_i && partial && (to_q >= ToLimit);

endmodule

// File: rtl/imem_load_controller.sv
// Loads a program from UART into instruction memory, else passes the fetch address through.
module imem_load_controller
  import imem_load_controller_pkg::*;
#(
  parameter int unsigned         PC_WIDTH       = 9,
  parameter int unsigned         NB_WIDTH       = 32,
  parameter int unsigned         NB_BYTE        = 8,
  parameter logic [NB_WIDTH-1:0] HALT_WORD      = NB_WIDTH'(HALT_WORD_DEFAULT),
  parameter int unsigned         TIMEOUT_CYCLES = 100000,
  parameter int unsigned         TO_WIDTH       = 17
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load_start,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic [PC_WIDTH-1:0] i_fetch_addr,
  output logic                o_mem_we,
  output logic [PC_WIDTH-1:0] o_mem_addr,
  output logic [NB_WIDTH-1:0] o_mem_wdata,
  output logic                o_busy,
  output logic                o_load_done,
  output logic                o_error
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [NB_WIDTH-1:0] wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                clear;
  logic                word_valid;
  logic [NB_WIDTH-1:0] word;
  logic                timeout;

  imem_load_controller_word_assembler #(
    .NB_WIDTH       (NB_WIDTH),
    .NB_BYTE        (NB_BYTE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_word_assembler (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .clear_i      (clear),
    .accept_en_i  ((state_q == StCollect) || (state_q == StWrite)),
    .collect_i    (state_q == StCollect),
    .rx_valid_i   (i_rx_valid),
    .rx_data_i    (i_rx_data),
    .word_valid_o (word_valid),
    .word_o       (word),
    .timeout_o    (timeout)
  );

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    clear     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_load_start) begin
          state_d   = StCollect;
          wr_addr_d = '0;
          err_d     = 1'b0;
          clear     = 1'b1;
        end
      end
      StCollect: begin
        if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else if (word_valid) begin
          wdata_d = word;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (wdata_q == HALT_WORD) begin
          state_d = StDone;
          err_d   = 1'b0;
        end else if (wr_addr_q == {PC_WIDTH{1'b1}}) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
          state_d   = StCollect;
          // Only reachable with one byte per word: a byte here already completes the next word.
          if (word_valid) begin
            wdata_d = word;
            state_d = StWrite;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
    end
  end

  assign o_mem_we    = (state_q == StWrite);
  assign o_mem_addr  = (state_q == StWrite) ? wr_addr_q : i_fetch_addr;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = (state_q == StCollect) || (state_q == StWrite);
  assign o_load_done = (state_q == StDone);
  assign o_error     = err_q;

endmodule

// File: tb/tb_imem_load_controller.sv
// Self-checking bench for imem_load_controller: write scoreboard plus vector tables.
module tb_imem_load_controller;

  localparam int unsigned PcW      = 9;
  localparam int unsigned NbW      = 32;
  localparam int unsigned NbB      = 8;
  localparam int unsigned ToCycles = 40;
  localparam int unsigned ToW      = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_start = 1'b0;
  logic [NbB-1:0] rx_data = '0;
  logic           rx_valid = 1'b0;
  logic [PcW-1:0] fetch_addr = '0;
  logic           mem_we;
  logic [PcW-1:0] mem_addr;
  logic [NbW-1:0] mem_wdata;
  logic           busy;
  logic           load_done;
  logic           error;

  imem_load_controller #(
    .PC_WIDTH       (PcW),
    .NB_WIDTH       (NbW),
    .NB_BYTE        (NbB),
    .HALT_WORD      (32'hFFFF_FFFF),
    .TIMEOUT_CYCLES (ToCycles),
    .TO_WIDTH       (ToW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_load_start (load_start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_fetch_addr (fetch_addr),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_busy       (busy),
    .o_load_done  (load_done),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [PcW-1:0] addr;
    logic [NbW-1:0] data;
  } wr_t;
  wr_t sb[$];
  logic [PcW-1:0] exp_addr = '0;

  typedef struct {
    logic [NbW-1:0] word;
    int             gap;
  } vec_t;
  vec_t vecs[6];
  logic [PcW-1:0] fetch_vals[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write the DUT performs must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, expected no write", mem_addr,
                 mem_wdata);
      end else begin
        e = sb.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e.addr));
        check("write_data", 64'(mem_wdata), 64'(e.data));
        check("busy_in_write", 64'(busy), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [NbB-1:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [NbW-1:0] w, input int gap);
    wr_t e;
    e.addr = exp_addr;
    e.data = w;
    sb.push_back(e);
    exp_addr = exp_addr + 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (i < 3) repeat (gap) tick();
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_addr   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int n = 0;
    while (!load_done && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, 64'(load_done), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hDEAD_BEEF, 0};
    vecs[1] = '{32'h0000_0001, 0};
    vecs[2] = '{32'hFFFF_FFFE, 0};
    vecs[3] = '{32'h8000_0000, 0};
    vecs[4] = '{32'hA5A5_5A5A, 0};
    vecs[5] = '{32'h7FFF_FFFF, 0};
    fetch_vals[0] = 9'h000;
    fetch_vals[1] = 9'h1FF;
    fetch_vals[2] = 9'h0AA;
    fetch_vals[3] = 9'h155;

    // Reset values while reset is held
    #2;
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single word, write lasts one cycle, word boundary never times out
    start_load();
    check("t1_busy", 64'(busy), 64'd1);
    send_word(32'h1234_5678, 0);
    check("t1_we_now", 64'(mem_we), 64'd1);
    tick();
    check("t1_we_one_cycle", 64'(mem_we), 64'd0);
    repeat (ToCycles + 20) tick();
    check("t1_idle_no_timeout_busy", 64'(busy), 64'd1);
    check("t1_idle_no_timeout_done", 64'(load_done), 64'd0);

    // 2: three words then HALT, with gaps between bytes
    do_reset();
    start_load();
    send_word(32'h0102_0304, 1);
    send_word(32'h1122_3344, 2);
    send_word(32'hCAFE_BABE, 3);
    send_word(32'hFFFF_FFFF, 0);
    check("t2_done_not_yet", 64'(load_done), 64'd0);
    tick();
    check("t2_done_latency", 64'(load_done), 64'd1);
    check("t2_error", 64'(error), 64'd0);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 4; i++) begin
      fetch_addr = fetch_vals[i];
      #1;
      check("t2_fetch_passthru", 64'(mem_addr), 64'(fetch_vals[i]));
      check("t2_fetch_we", 64'(mem_we), 64'd0);
    end

    // 3: restart from DONE, back-to-back bytes incl. one in each WRITE cycle
    start_load();
    check("t3_restart_done", 64'(load_done), 64'd0);
    foreach (vecs[i]) send_word(vecs[i].word, vecs[i].gap);
    send_word(32'hFFFF_FFFF, 0);
    tick();
    check("t3_done", 64'(load_done), 64'd1);
    check("t3_error", 64'(error), 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // 4: fill all 512 locations without HALT -> overflow
    start_load();
    for (int i = 0; i < 512; i++) send_word({16'(i), 16'hA5C3}, 0);
    tick();
    check("t4_done", 64'(load_done), 64'd1);
    check("t4_overflow_error", 64'(error), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // 5: partial word stall -> timeout, nothing written; new start clears error
    start_load();
    check("t5_start_clears_error", 64'(error), 64'd0);
    send_byte(8'h9A);
    send_byte(8'hBC);
    repeat (ToCycles - 5) tick();
    check("t5_still_busy", 64'(busy), 64'd1);
    wait_done(50, "t5_timeout_done");
    check("t5_timeout_error", 64'(error), 64'd1);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);
    start_load();
    check("t5_restart_error", 64'(error), 64'd0);
    check("t5_restart_busy", 64'(busy), 64'd1);

    // 6: async reset mid-word after one write; bytes in IDLE are then ignored
    send_word(32'hCAFE_F00D, 0);
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    fetch_addr = 9'h0C3;
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(load_done), 64'd0);
    check("t6_rst_error", 64'(error), 64'd0);
    check("t6_rst_we", 64'(mem_we), 64'd0);
    check("t6_rst_wdata", 64'(mem_wdata), 64'd0);
    check("t6_rst_addr", 64'(mem_addr), 64'h0C3);
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (3) tick();
    check("t6_idle_busy", 64'(busy), 64'd0);
    check("t6_idle_done", 64'(load_done), 64'd0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
